// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Multicycle multiply/divide unit producing the Hi/Lo pair.
//               Shift-add multiplication and restoring division, one bit
//               per cycle, signed or unsigned, with a start/done handshake.
// Ports       : clk, reset (sync, active-high)
//               start_mult / start_div  - one-cycle requests (IDLE only)
//               is_signed, op_a, op_b   - sampled with the accepted start
//               busy                    - operation in progress
//               done                    - one-cycle result-valid pulse
//               div_zero                - pulses with done on divide by zero
//               hi_out / lo_out         - product hi/lo or remainder/quotient
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MULT   = 2'd1,
        S_DIV    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_nextState;

    logic [CW-1:0]        r_count;
    logic [2*WIDTH-1:0]   r_acc;      // mult: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]     r_operand;  // multiplicand or divisor magnitude
    logic                 r_negLo;    // negate product / quotient
    logic                 r_negHi;    // negate remainder (dividend sign)
    logic                 r_isDiv;
    logic                 r_divZero;

    logic                 w_lastIter;
    logic                 w_negA, w_negB;
    logic [WIDTH-1:0]     w_magA, w_magB;
    logic [WIDTH:0]       w_addSum;
    logic [2*WIDTH-1:0]   w_multNext;
    logic [WIDTH:0]       w_remWide;
    logic                 w_trialOk;
    logic [WIDTH-1:0]     w_remDiff;
    logic [2*WIDTH-1:0]   w_divNext;
    logic [2*WIDTH-1:0]   w_product;
    logic [WIDTH-1:0]     w_quot, w_rem;

    assign w_lastIter = (r_count == CW'(WIDTH - 1));

    // Operand magnitudes; the most-negative value maps onto itself, which is
    // the correct unsigned magnitude.
    assign w_negA = is_signed & op_a[WIDTH-1];
    assign w_negB = is_signed & op_b[WIDTH-1];
    assign w_magA = w_negA ? -op_a : op_a;
    assign w_magB = w_negB ? -op_b : op_b;

    // Multiply step: conditional add into the upper half, then shift the
    // carry back in from the top.
    assign w_addSum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_operand} : '0);
    assign w_multNext = {w_addSum, r_acc[WIDTH-1:1]};

    // Divide step: the shifted remainder needs one extra bit because it can
    // reach almost twice the divisor. The difference always fits in WIDTH.
    assign w_remWide = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_trialOk = (w_remWide >= {1'b0, r_operand});
    assign w_remDiff = w_remWide[WIDTH-1:0] - r_operand;
    assign w_divNext = w_trialOk ? {w_remDiff, r_acc[WIDTH-2:0], 1'b1}
                                 : {w_remWide[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

    assign w_product = r_negLo ? -r_acc : r_acc;
    assign w_quot    = r_negLo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem     = r_negHi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_mult)          w_nextState = S_MULT;
                else if (start_div)      w_nextState = (op_b == '0) ? S_FINISH : S_DIV;
            end
            S_MULT:   if (w_lastIter) w_nextState = S_FINISH;
            S_DIV:    if (w_lastIter) w_nextState = S_FINISH;
            S_FINISH: w_nextState = S_IDLE;
            default:  w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= '0;
            r_acc     <= '0;
            r_operand <= '0;
            r_negLo   <= 1'b0;
            r_negHi   <= 1'b0;
            r_isDiv   <= 1'b0;
            r_divZero <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            hi_out    <= '0;
            lo_out    <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_mult || start_div) begin
                        r_count   <= '0;
                        r_operand <= start_mult ? w_magA : w_magB;
                        r_acc     <= {{WIDTH{1'b0}}, (start_mult ? w_magB : w_magA)};
                        r_negLo   <= w_negA ^ w_negB;
                        r_negHi   <= w_negA;
                        r_isDiv   <= ~start_mult;
                        r_divZero <= ~start_mult & (op_b == '0);
                    end
                end
                S_MULT: begin
                    r_acc   <= w_multNext;
                    r_count <= r_count + 1'b1;
                end
                S_DIV: begin
                    r_acc   <= w_divNext;
                    r_count <= r_count + 1'b1;
                end
                S_FINISH: begin
                    done     <= 1'b1;
                    div_zero <= r_divZero;
                    if (!r_divZero) begin
                        if (r_isDiv) begin
                            hi_out <= w_rem;
                            lo_out <= w_quot;
                        end else begin
                            hi_out <= w_product[2*WIDTH-1:WIDTH];
                            lo_out <= w_product[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
